// File: rtl/cla8_seq_adder_ctrl.sv
// Byte-serial WIDTH-bit add/subtract controller driving an external 8-bit CLA slice.
// Operands are latched on accept; one byte per RUN cycle, LSB first, carry chained through a flop.
module cla8_seq_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             op_cin,
  output logic [7:0]       cla_a,
  output logic [7:0]       cla_b,
  output logic             cla_cin,
  input  logic [7:0]       cla_sum,
  input  logic             cla_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             busy
);
  localparam int N  = WIDTH / 8;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nxt;
  logic             carry_reg;
  logic [IW-1:0]    idx;
  logic             last, accept;

  assign last   = (idx == IW'(N - 1));
  assign accept = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && !rst;
    res_valid = (state == DONE);
    busy      = (state != IDLE);
    cla_a     = 8'h00;
    cla_b     = 8'h00;
    cla_cin   = 1'b0;
    sum_nxt   = sum_reg;
    unique case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        cla_a   = a_reg[{idx, 3'b000} +: 8];
        cla_b   = b_reg[{idx, 3'b000} +: 8];
        cla_cin = carry_reg;
        sum_nxt[{idx, 3'b000} +: 8] = cla_sum;
        if (last) state_nxt = DONE;
      end
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (accept) begin
          a_reg     <= op_a;
          b_reg     <= op_sub ? ~op_b : op_b;
          carry_reg <= op_sub ? 1'b1 : op_cin;
          idx       <= '0;
          sum_reg   <= '0;
        end
        RUN: begin
          sum_reg   <= sum_nxt;
          carry_reg <= cla_cout;
          if (last) begin
            // Result registers are separate from sum_reg so they hold through the next RUN.
            idx      <= '0;
            res_sum  <= sum_nxt;
            res_cout <= cla_cout;
            res_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[7] != a_reg[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cla8_seq_adder_ctrl.sv
// Bench for cla8_seq_adder_ctrl: 32-bit and 8-bit instances, each with a behavioural CLA slice.
module tb_cla8_seq_adder_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        in_valid, in_ready, op_sub, op_cin, res_valid, res_ready, res_cout, res_ovf, busy;
  logic [31:0] op_a, op_b, res_sum;
  logic [7:0]  cla_a, cla_b, cla_sum;
  logic        cla_cin, cla_cout;

  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {8'b0, cla_cin};

  cla8_seq_adder_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin), .cla_sum(cla_sum), .cla_cout(cla_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy));

  // 8-bit instance
  logic       in_valid8, in_ready8, op_sub8, op_cin8, res_valid8, res_cout8, res_ovf8, busy8;
  logic [7:0] op_a8, op_b8, res_sum8, cla_a8, cla_b8, cla_sum8;
  logic       cla_cin8, cla_cout8;

  assign {cla_cout8, cla_sum8} = {1'b0, cla_a8} + {1'b0, cla_b8} + {8'b0, cla_cin8};

  cla8_seq_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .op_a(op_a8), .op_b(op_b8), .op_sub(op_sub8), .op_cin(op_cin8),
    .cla_a(cla_a8), .cla_b(cla_b8), .cla_cin(cla_cin8), .cla_sum(cla_sum8), .cla_cout(cla_cout8),
    .res_valid(res_valid8), .res_ready(1'b1), .res_sum(res_sum8),
    .res_cout(res_cout8), .res_ovf(res_ovf8), .busy(busy8));

  int npass = 0;
  int nchk  = 0;
  logic [7:0] cin_log;
  logic [7:0] b0_log;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [31:0] a, b, input logic sub, cin,
                       output logic [31:0] s, output logic co, ov);
    longint ua, ub, sa, sb, u, r;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    if (sub) begin
      u  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end else begin
      u  = ua + ub + longint'(cin);
      co = (u >= 64'sh1_0000_0000);
      r  = sa + sb + longint'(cin);
    end
    s  = u[31:0];
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endtask

  task automatic start_op(input logic [31:0] a, b, input logic sub, cin);
    int w;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; op_sub = sub; op_cin = cin;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) check("accept_timeout", 64'(w), 64'd0);
    @(posedge clk); #1;
    // Scramble operands after accept: the controller must have latched them.
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; op_sub = 1'($urandom); op_cin = 1'($urandom);
  endtask

  task automatic wait_result(output int lat);
    lat = 0; cin_log = '0; b0_log = '0;
    while (!res_valid && lat < 20) begin
      if (lat < 8) cin_log[lat] = cla_cin;
      if (lat == 0) b0_log = cla_b;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) check("result_timeout", 64'(lat), 64'd4);
  endtask

  task automatic do_op(input logic [31:0] a, b, input logic sub, cin,
                       output logic [31:0] s, output logic co, ov, output int lat);
    start_op(a, b, sub, cin);
    wait_result(lat);
    s = res_sum; co = res_cout; ov = res_ovf;
    @(posedge clk); #1;
  endtask

  task automatic op8(input logic [7:0] a, b, input logic sub, cin,
                     output logic [7:0] s, output logic co, ov, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; op_a8 = a; op_b8 = b; op_sub8 = sub; op_cin8 = cin;
    @(posedge clk); #1;
    in_valid8 = 1'b0; op_a8 = 8'($urandom); op_b8 = 8'($urandom);
    lat = 0;
    while (!res_valid8 && lat < 20) begin @(posedge clk); #1; lat++; end
    s = res_sum8; co = res_cout8; ov = res_ovf8;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        sub, cin;
    logic [31:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [31:0] s, ms, s1;
    logic [7:0]  s8;
    logic        co, ov, mco, mov, stable;
    int          lat;

    vt[0] = '{32'h00FF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vt[1] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vt[2] = '{32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[3] = '{32'h0000_0005, 32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[4] = '{32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
    vt[5] = '{32'h0000_000A, 32'h3, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b1;
    op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0;
    in_valid8 = 1'b0; op_a8 = '0; op_b8 = '0; op_sub8 = 1'b0; op_cin8 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_res_sum",   64'(res_sum), 64'd0);
    check("rst_cla_out",   64'({cla_a, cla_b, cla_cin}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i),  64'(s),  64'(vt[i].es));
      check($sformatf("vec%0d_cout", i), 64'(co), 64'(vt[i].ec));
      check($sformatf("vec%0d_ovf", i),  64'(ov), 64'(vt[i].eo));
      check($sformatf("vec%0d_lat", i),  64'(lat), 64'd4);
      if (i == 0) check("ripple_cla_cin_seq", 64'(cin_log[3:0]), 64'b1110);
      if (i == 3) check("sub_cla_b_inverted", 64'(b0_log), 64'hF8);
    end
    check("idle_cla_out", 64'({cla_a, cla_b, cla_cin}), 64'd0);

    // Reset in the middle of RUN
    start_op(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    stable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (res_valid || busy || in_ready) stable = 1'b0;
    end
    check("midrun_rst_quiet", 64'(stable), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
    check("midrun_rst_res_sum",  64'(res_sum), 64'd0);
    stable = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (res_valid) stable = 1'b0; end
    check("midrun_rst_no_valid", 64'(stable), 64'd1);

    // Backpressure with a held second request
    res_ready = 1'b0;
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_result(lat);
    s1 = res_sum;
    check("bp_first_sum", 64'(s1), 64'h2345_6789);
    @(negedge clk);
    in_valid = 1'b1; op_a = 32'h0000_0100; op_b = 32'h0000_0001; op_sub = 1'b1; op_cin = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (!res_valid || res_sum !== s1 || in_ready || !busy) stable = 1'b0;
    end
    check("bp_hold_stable", 64'(stable), 64'd1);
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_handshake_idle", 64'({busy, res_valid}), 64'd0);
    check("bp_held_sum_kept",  64'(res_sum), 64'(s1));
    @(posedge clk); #1;
    check("bp_second_accepted", 64'(busy), 64'd1);
    in_valid = 1'b0;
    wait_result(lat);
    check("bp_second_sum", 64'(res_sum), 64'h0000_00FF);
    check("bp_second_lat", 64'(lat), 64'd4);
    @(posedge clk); #1;

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        sb, ci;
      a  = (i % 8 == 0) ? 32'h7FFF_FFFF : $urandom;
      b  = (i % 8 == 1) ? 32'h8000_0000 : $urandom;
      sb = 1'($urandom); ci = 1'($urandom);
      do_op(a, b, sb, ci, s, co, ov, lat);
      model(a, b, sb, ci, ms, mco, mov);
      check($sformatf("rand%0d_res", i), {31'd0, co, ov, s}, {31'd0, mco, mov, ms});
      if (lat != 4) check($sformatf("rand%0d_lat", i), 64'(lat), 64'd4);
    end

    // WIDTH=8 instance
    op8(8'h7F, 8'h01, 1'b0, 1'b0, s8, co, ov, lat);
    check("w8_lat",  64'(lat), 64'd1);
    check("w8_sum",  64'(s8), 64'h80);
    check("w8_ovf",  64'(ov), 64'd1);
    check("w8_cout", 64'(co), 64'd0);
    op8(8'h00, 8'h01, 1'b1, 1'b0, s8, co, ov, lat);
    check("w8_sub_res", 64'({co, ov, s8}), 64'h0FF);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", npass, nchk);
    $fatal(1);
  end
endmodule

// File: doc/cla8_seq_adder_ctrl.md
# cla8_seq_adder_ctrl

Sequencing controller that time-shares one 8-bit carry-lookahead adder slice to perform WIDTH-bit add/subtract, one byte per cycle, least-significant byte first. It owns the operand and result registers, chains the carry between slices through a flop, and presents valid/ready handshakes on the operand and result sides. The CLA slice is instantiated outside this block; the controller drives its inputs combinationally and samples its outputs every cycle.

## Interface
- WIDTH, 32, operand/result width in bits; multiple of 8, minimum 8; N = WIDTH/8 byte slices
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  controller can accept; high only in IDLE and rst low
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- op_sub  in  1  1 = A − B, 0 = A + B + op_cin
- op_cin  in  1  carry-in for add; ignored when op_sub=1
- cla_a  out  8  slice operand A byte
- cla_b  out  8  slice operand B byte (already inverted for subtract)
- cla_cin  out  1  slice carry-in
- cla_sum  in  8  slice sum from CLA
- cla_cout  in  1  slice carry-out from CLA
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_sum  out  WIDTH  result
- res_cout  out  1  final carry-out (for subtract: 1 = no borrow)
- res_ovf  out  1  signed two's-complement overflow
- busy  out  1  state is RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: a_reg←op_a; b_reg←op_sub ? ~op_b : op_b; carry_reg←op_sub ? 1 : op_cin; idx←0; sum_reg←0; go RUN.
- RUN: cla_a=a_reg[8*idx+:8], cla_b=b_reg[8*idx+:8], cla_cin=carry_reg. Each edge: sum_reg[8*idx+:8]←cla_sum, carry_reg←cla_cout, idx←idx+1. On edge with idx==N−1: go DONE, res_cout←cla_cout, res_ovf←(a_reg[WIDTH−1]==b_reg[WIDTH−1]) && (cla_sum[7]!=a_reg[WIDTH−1]).
- DONE: res_valid=1, res_sum=sum_reg; hold all result outputs stable while res_ready=0. On res_valid&&res_ready go IDLE.
- Outside RUN: cla_a=0, cla_b=0, cla_cin=0.
- idx width max(1,$clog2(N)); never exceeds N−1; no wrap in normal operation.
- res_sum/res_cout/res_ovf retain last value in IDLE until next result overwrites them; only res_valid qualifies them.
- in_valid ignored in RUN/DONE; op_* need only be stable in the accept cycle.
- WIDTH=8: RUN lasts exactly one cycle.

## Timing
- Reset (edge with rst=1): state IDLE, idx 0, res_valid 0, res_sum 0, res_cout 0, res_ovf 0, busy 0, cla_* 0; in_ready forced 0 while rst high, 1 the cycle after.
- rst asserted mid-RUN or in DONE: operation aborted, no res_valid pulse, all outputs to reset values next cycle.
- Accept at edge E0 → RUN cycles E0..E_N → res_valid high from edge E_N (N cycles after accept; 4 for WIDTH=32).
- Result handshake edge returns to IDLE; next accept earliest one cycle later. Throughput with res_ready held 1: one op per N+2 cycles.
- in_valid asserted in the same cycle as the result handshake is not accepted (in_ready=0); held request accepted on the following edge.
- Slice is combinational: cla_sum/cla_cout must settle within one clock period from cla_* change.

## Test plan
- Reset: rst high 2 cycles mid-RUN of 0x0000FFFF+0x1 → res_valid stays 0, in_ready 1 cycle after rst drops, res_sum=0.
- Add with carry ripple: A=0x00FF_FFFF, B=0x1, cin=0, sub=0 → res_valid 4 cycles after accept, res_sum=0x0100_0000, res_cout=0, res_ovf=0; cla_cin sequence 0,1,1,1.
- Full wrap: A=0xFFFF_FFFF, B=0x1, cin=1 → res_sum=0x0000_0001, res_cout=1, res_ovf=0.
- Subtract/overflow: A=0x8000_0000, B=0x1, sub=1 → res_sum=0x7FFF_FFFF, res_cout=1, res_ovf=1; A=0x5, B=0x7, sub=1 → 0xFFFF_FFFE, res_cout=0, res_ovf=0.
- Backpressure: res_ready=0 for 5 cycles in DONE → res_valid and res_sum stable, in_ready 0, second in_valid ignored until one cycle after handshake.
- WIDTH=8 instance: A=0x7F, B=0x01 → res_valid 1 cycle after accept, res_sum=0x80, res_ovf=1, res_cout=0.
